// File: rtl/feature_sequencer.sv
// feature_sequencer: paces accelerometer reads from a programmable sample tick, hands each
// captured sample to the magnitude/feature pipeline with a one-cycle start pulse, counts
// samples per analysis window and presents the window's mean/std over a valid/ready handshake.
//
// Optional feature macro: SEQ_TIMEOUT_EN -- when defined, WAIT_MAG/WAIT_FEAT give up after
// TIMEOUT_CYC cycles, set err_timeout and abandon the window. Undefined: wait forever,
// err_timeout tied to 0.
//
// Ports:
//   i_clk, i_reset_n                 clock, asynchronous active-low reset
//   i_enable, i_clr_err              run request, clear sticky flags
//   i_sens_valid / o_sens_ready      sensor handshake; i_sens_x/y/z raw samples
//   o_pipe_start, o_pipe_x/y/z       start pulse and registered sample to the pipeline
//   i_pipe_mag_valid                 per-sample magnitude done
//   i_pipe_feat_valid, i_pipe_mean/std  window features from the pipeline
//   o_win_valid / i_win_ready        result handshake; o_win_mean/std latched features
//   o_sample_cnt                     samples accepted in the current window
//   o_overrun, o_err_timeout         sticky error flags
module feature_sequencer #(
  parameter int unsigned SAMPLE_DIV  = 1000,
  parameter int unsigned WINDOW_LEN  = 50,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_enable,
  input  logic        i_clr_err,
  input  logic        i_sens_valid,
  output logic        o_sens_ready,
  input  logic [15:0] i_sens_x,
  input  logic [15:0] i_sens_y,
  input  logic [15:0] i_sens_z,
  output logic        o_pipe_start,
  output logic [15:0] o_pipe_x,
  output logic [15:0] o_pipe_y,
  output logic [15:0] o_pipe_z,
  input  logic        i_pipe_mag_valid,
  input  logic        i_pipe_feat_valid,
  input  logic [15:0] i_pipe_mean,
  input  logic [15:0] i_pipe_std,
  output logic        o_win_valid,
  input  logic        i_win_ready,
  output logic [15:0] o_win_mean,
  output logic [15:0] o_win_std,
  output logic [7:0]  o_sample_cnt,
  output logic        o_overrun,
  output logic        o_err_timeout
);

  if (SAMPLE_DIV < 8 || WINDOW_LEN < 1 || WINDOW_LEN > 255 || TIMEOUT_CYC < 1) begin : g_cfg_chk
    $error("feature_sequencer: parameter out of range");
  end

  localparam int unsigned      TickW    = $clog2(SAMPLE_DIV);
  localparam logic [TickW-1:0] TickLast = TickW'(SAMPLE_DIV - 1);
  localparam logic [7:0]       WinLen   = 8'(WINDOW_LEN);

  typedef enum logic [2:0] {
    StIdle, StWaitTick, StCapture, StIssue, StWaitMag, StWaitFeat, StHold
  } state_e;

  state_e           r_state, w_state_nxt;
  logic [TickW-1:0] r_tick_cnt, w_tick_cnt_nxt;
  logic [7:0]       r_sample_cnt, w_sample_cnt_nxt, w_sample_inc;
  logic [15:0]      r_pipe_x, r_pipe_y, r_pipe_z;
  logic [15:0]      r_win_mean, r_win_std;
  logic             r_win_valid, w_win_valid_nxt;
  logic             r_overrun, w_overrun_nxt;
  logic             w_tick, w_capture, w_win_load, w_timeout;
  logic             w_sens_ready, w_pipe_start;

  // Free-running divider; held at 0 in IDLE so a fresh run waits a full period.
  always_comb begin
    w_tick         = (r_state != StIdle) && (r_tick_cnt == TickLast);
    w_tick_cnt_nxt = (r_state == StIdle || w_tick) ? '0 : r_tick_cnt + TickW'(1);
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned      WaitW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYC - 1);

  logic [WaitW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic             r_err_timeout, w_err_timeout_nxt, w_err_set;

  always_comb begin
    w_timeout      = (r_state == StWaitMag || r_state == StWaitFeat) && (r_wait_cnt == WaitLast);
    // Any state change restarts the count, so entry into either wait state starts at 0.
    w_wait_cnt_nxt = (w_state_nxt != r_state) ? '0 : r_wait_cnt + WaitW'(1);
    // A response arriving on the last wait cycle still wins over the timeout.
    w_err_set      = w_timeout &&
                     !((r_state == StWaitMag  && i_pipe_mag_valid) ||
                       (r_state == StWaitFeat && i_pipe_feat_valid));
    w_err_timeout_nxt = w_err_set ? 1'b1 : (i_clr_err ? 1'b0 : r_err_timeout);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wait_cnt    <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_err_timeout <= w_err_timeout_nxt;
    end
  end

  assign o_err_timeout = r_err_timeout;
`else
  assign w_timeout     = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_sample_cnt_nxt = r_sample_cnt;
    w_sample_inc     = r_sample_cnt + 8'd1;
    w_win_valid_nxt  = r_win_valid;
    w_capture        = 1'b0;
    w_win_load       = 1'b0;
    w_sens_ready     = 1'b0;
    w_pipe_start     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_enable) begin
          w_state_nxt      = StWaitTick;
          w_sample_cnt_nxt = '0;
        end
      end
      StWaitTick: begin
        if (!i_enable) begin
          w_state_nxt      = StIdle;
          w_sample_cnt_nxt = '0;
        end else if (w_tick) begin
          w_state_nxt = StCapture;
        end
      end
      StCapture: begin
        w_sens_ready = 1'b1;
        if (i_sens_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = StIssue;
        end else if (!i_enable) begin
          w_state_nxt = StIdle;
        end
      end
      StIssue: begin
        w_pipe_start = 1'b1;
        w_state_nxt  = StWaitMag;
      end
      StWaitMag: begin
        if (i_pipe_mag_valid) begin
          w_sample_cnt_nxt = w_sample_inc;
          w_state_nxt      = (w_sample_inc == WinLen) ? StWaitFeat : StWaitTick;
        end else if (w_timeout) begin
          w_sample_cnt_nxt = '0;
          w_state_nxt      = StWaitTick;
        end
      end
      StWaitFeat: begin
        if (i_pipe_feat_valid) begin
          w_win_load      = 1'b1;
          w_win_valid_nxt = 1'b1;
          w_state_nxt     = StHold;
        end else if (w_timeout) begin
          w_sample_cnt_nxt = '0;
          w_state_nxt      = StWaitTick;
        end
      end
      StHold: begin
        if (i_win_ready) begin
          w_win_valid_nxt  = 1'b0;
          w_sample_cnt_nxt = '0;
          w_state_nxt      = i_enable ? StWaitTick : StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // Ticks only have a home in WAIT_TICK (or IDLE, where none occur); elsewhere they are lost.
    if (w_tick && !(r_state == StIdle || r_state == StWaitTick)) begin
      w_overrun_nxt = 1'b1;
    end else if (i_clr_err) begin
      w_overrun_nxt = 1'b0;
    end else begin
      w_overrun_nxt = r_overrun;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= StIdle;
      r_tick_cnt   <= '0;
      r_sample_cnt <= '0;
      r_pipe_x     <= '0;
      r_pipe_y     <= '0;
      r_pipe_z     <= '0;
      r_win_valid  <= 1'b0;
      r_win_mean   <= '0;
      r_win_std    <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tick_cnt   <= w_tick_cnt_nxt;
      r_sample_cnt <= w_sample_cnt_nxt;
      r_win_valid  <= w_win_valid_nxt;
      r_overrun    <= w_overrun_nxt;
      if (w_capture) begin
        r_pipe_x <= i_sens_x;
        r_pipe_y <= i_sens_y;
        r_pipe_z <= i_sens_z;
      end
      if (w_win_load) begin
        r_win_mean <= i_pipe_mean;
        r_win_std  <= i_pipe_std;
      end
    end
  end

  assign o_sens_ready = w_sens_ready;
  assign o_pipe_start = w_pipe_start;
  assign o_pipe_x     = r_pipe_x;
  assign o_pipe_y     = r_pipe_y;
  assign o_pipe_z     = r_pipe_z;
  assign o_win_valid  = r_win_valid;
  assign o_win_mean   = r_win_mean;
  assign o_win_std    = r_win_std;
  assign o_sample_cnt = r_sample_cnt;
  assign o_overrun    = r_overrun;

endmodule

// File: doc/feature_sequencer.md
# feature_sequencer

Sampling and window controller that drives the fall-detection feature datapath. It paces accelerometer reads from a programmable sample tick and hands each captured sample to the magnitude/feature pipeline with a one-cycle start pulse. It counts samples per analysis window, then latches the window's mean/std result and presents it to the downstream classifier through a valid/ready handshake. It sits between the sensor front-end and the feature pipeline.

## Interface
- SAMPLE_DIV, 1000, clock cycles per sample tick (≥ 8)
- WINDOW_LEN, 50, samples per window (1..255)
- TIMEOUT_CYC, 64, max cycles waiting on a pipeline response (used only with SEQ_TIMEOUT_EN)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run request
- clr_err  in  1  clears sticky flags
- sens_valid / sens_ready  in / out  1  sensor sample handshake
- sens_x, sens_y, sens_z  in  16  raw axis samples
- pipe_start  out  1  one-cycle start to the magnitude stage
- pipe_x, pipe_y, pipe_z  out  16  registered sample to the pipeline
- pipe_mag_valid  in  1  per-sample magnitude done
- pipe_feat_valid  in  1  window features ready
- pipe_mean, pipe_std  in  16  pipeline feature outputs
- win_valid / win_ready  out / in  1  result handshake to the classifier
- win_mean, win_std  out  16  latched window features
- sample_cnt  out  8  samples accepted in the current window
- overrun  out  1  sticky: tick arrived while busy
- err_timeout  out  1  sticky: pipeline response timeout

## Operation
- States: IDLE, WAIT_TICK, CAPTURE, ISSUE, WAIT_MAG, WAIT_FEAT, HOLD.
- IDLE: when enable=1, go to WAIT_TICK, with sample_cnt=0 and the tick counter at 0.
- WAIT_TICK: on tick, go to CAPTURE. If enable=0, go to IDLE and clear sample_cnt.
- CAPTURE: sens_ready=1. On sens_valid&sens_ready, latch x/y/z into pipe_x/y/z and go to ISSUE. If enable=0 before the handshake, go to IDLE.
- ISSUE: pipe_start=1 for exactly this cycle, then go to WAIT_MAG.
- WAIT_MAG: on pipe_mag_valid, sample_cnt+1. If the new count equals WINDOW_LEN, go to WAIT_FEAT; otherwise go to WAIT_TICK.
- WAIT_FEAT: on pipe_feat_valid, latch pipe_mean/pipe_std into win_mean/win_std, set win_valid, and go to HOLD.
- HOLD: on win_valid&win_ready, clear win_valid, set sample_cnt=0, and go to WAIT_TICK (or IDLE if enable=0).
- enable is ignored in ISSUE, WAIT_MAG, WAIT_FEAT and HOLD; the current sample or window always completes.
- Tick counter: runs 0..SAMPLE_DIV-1 while state≠IDLE. Tick is the cycle where count==SAMPLE_DIV-1.
- Overrun: a tick in any state other than WAIT_TICK or IDLE is dropped and sets overrun.
- clr_err=1 clears overrun and err_timeout the next cycle. A set condition in the same cycle wins over the clear.
- win_mean/win_std stay stable while win_valid=1.

## Timing
- Reset values: all outputs 0, state IDLE, tick counter 0.
- pipe_start is high the cycle after the sensor handshake. pipe_x/y/z are valid from that cycle and hold until the next capture.
- sample_cnt updates the cycle after pipe_mag_valid is sampled.
- win_valid rises the cycle after pipe_feat_valid. The earliest next tick accepted is the cycle after the win handshake.
- pipe_mag_valid and pipe_feat_valid are ignored outside WAIT_MAG and WAIT_FEAT.
- Reset asserted mid-window: everything returns to reset values immediately, and the partial window is discarded.

## Configuration
- SEQ_TIMEOUT_EN defined: a wait counter clears on entering WAIT_MAG or WAIT_FEAT.
  - After TIMEOUT_CYC cycles without the expected response, err_timeout is set, sample_cnt is cleared, and the FSM goes to WAIT_TICK, abandoning the window.
- SEQ_TIMEOUT_EN undefined: WAIT_MAG and WAIT_FEAT wait indefinitely, TIMEOUT_CYC is unused, and err_timeout is tied to 0.

## Test plan
- SAMPLE_DIV=16, WINDOW_LEN=4, sensor always valid, pipeline acks mag 3 cycles after start:
  - Expect 4 pipe_start pulses, 16 cycles apart.
  - sample_cnt goes 1,2,3,4.
  - Then pipe_feat_valid with mean=0x1234, std=0x0056 → win_valid with exactly those values.
- Hold win_ready=0 for 40 cycles → win_valid and values stay stable, overrun=1. A later clr_err=1 → overrun=0.
- Sensor stalls sens_valid for 5 cycles after a tick → sens_ready stays high and pipe_start rises the cycle after the handshake.
- enable drops in WAIT_TICK with sample_cnt=2 → IDLE, sample_cnt=0. enable drops in WAIT_MAG → the sample completes first, then the FSM continues.
- With SEQ_TIMEOUT_EN and TIMEOUT_CYC=64, no pipe_mag_valid → err_timeout=1 at wait cycle 64 and sample_cnt=0. Without the macro → the FSM stays in WAIT_MAG.
- reset_n pulsed low mid-window → all outputs 0 asynchronously; after release with enable=1, a fresh window starts from sample_cnt=0.
